// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Radix-2 shift-add multiply, restoring divide, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_IDEX,
    input  logic [2:0]       funct3_IDEX,
    input  logic [WIDTH-1:0] rs1_data_IDEX,
    input  logic [WIDTH-1:0] rs2_data_IDEX,
    input  logic [4:0]       rd_IDEX,
    input  logic             flush_EX,
    output logic             stall_EX,
    output logic             done_EXMEM,
    output logic [WIDTH-1:0] result_EXMEM,
    output logic [4:0]       rd_EXMEM,
    output logic             reg_wr_en_EXMEM
);

    localparam int             c_CNT_W    = $clog2(CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CYCLES - 1);
    localparam logic [WIDTH-1:0]   c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_funct3;
    logic [4:0]           r_rd;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_b;

    // Operand decode on the incoming instruction
    logic                 w_is_div;
    logic                 w_a_signed;
    logic                 w_b_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_abs;
    logic [WIDTH-1:0]     w_b_abs;
    logic                 w_div_zero;
    logic                 w_div_ovf;
    logic [WIDTH-1:0]     w_special_res;

    always_comb begin
        w_is_div      = funct3_IDEX[2];
        w_a_signed    = w_is_div ? ~funct3_IDEX[0] : (funct3_IDEX[1:0] != 2'b11);
        w_b_signed    = w_is_div ? ~funct3_IDEX[0] : ~funct3_IDEX[1];
        w_a_neg       = w_a_signed & rs1_data_IDEX[WIDTH-1];
        w_b_neg       = w_b_signed & rs2_data_IDEX[WIDTH-1];
        w_a_abs       = w_a_neg ? -rs1_data_IDEX : rs1_data_IDEX;
        w_b_abs       = w_b_neg ? -rs2_data_IDEX : rs2_data_IDEX;
        w_div_zero    = w_is_div & (rs2_data_IDEX == '0);
        w_div_ovf     = w_is_div & ~funct3_IDEX[0] & (rs1_data_IDEX == c_MIN_NEG)
                      & (rs2_data_IDEX == '1);
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3_IDEX[1] ? rs1_data_IDEX : '1;
        end else if (w_div_ovf) begin
            w_special_res = funct3_IDEX[1] ? '0 : c_MIN_NEG;
        end
    end

    // One iteration: r_hi is product-high / remainder, r_lo is multiplier / dividend-quotient
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_trial;
    logic                 w_borrow;
    logic [WIDTH-1:0]     w_hi_nxt;
    logic [WIDTH-1:0]     w_lo_nxt;

    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
        w_borrow    = w_div_trial[WIDTH];
        if (r_funct3[2]) begin
            w_hi_nxt = w_borrow ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_div_trial[WIDTH-1:0];
            w_lo_nxt = {r_lo[WIDTH-2:0], ~w_borrow};
        end else begin
            w_hi_nxt = w_mul_sum[WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and result select for the final iteration
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_result;

    always_comb begin
        w_prod_fix = r_neg_res ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
        w_quo_fix  = r_neg_res ? -w_lo_nxt : w_lo_nxt;
        w_rem_fix  = r_neg_rem ? -w_hi_nxt : w_hi_nxt;
        case (r_funct3)
            3'b000:          w_result = w_prod_fix[WIDTH-1:0];
            3'b100, 3'b101:  w_result = w_quo_fix;
            3'b110, 3'b111:  w_result = w_rem_fix;
            default:         w_result = w_prod_fix[2*WIDTH-1:WIDTH];
        endcase
    end

    assign stall_EX = ((r_state == S_IDLE) & start_IDEX & ~flush_EX) | (r_state == S_CALC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_funct3        <= '0;
            r_rd            <= '0;
            r_neg_res       <= 1'b0;
            r_neg_rem       <= 1'b0;
            r_hi            <= '0;
            r_lo            <= '0;
            r_b             <= '0;
            done_EXMEM      <= 1'b0;
            reg_wr_en_EXMEM <= 1'b0;
            result_EXMEM    <= '0;
            rd_EXMEM        <= '0;
        end else begin
            done_EXMEM      <= 1'b0;
            reg_wr_en_EXMEM <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_IDEX && !flush_EX) begin
                        r_funct3 <= funct3_IDEX;
                        if (w_div_zero || w_div_ovf) begin
                            result_EXMEM    <= w_special_res;
                            rd_EXMEM        <= rd_IDEX;
                            done_EXMEM      <= 1'b1;
                            reg_wr_en_EXMEM <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            r_rd      <= rd_IDEX;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_hi      <= '0;
                            r_lo      <= w_is_div ? w_a_abs : w_b_abs;
                            r_b       <= w_is_div ? w_b_abs : w_a_abs;
                            r_cnt     <= c_CNT_LAST;
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_EX) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hi <= w_hi_nxt;
                        r_lo <= w_lo_nxt;
                        if (r_cnt == '0) begin
                            result_EXMEM    <= w_result;
                            rd_EXMEM        <= r_rd;
                            done_EXMEM      <= 1'b1;
                            reg_wr_en_EXMEM <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Same instruction is still in ID/EX here, so start is ignored
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_IDEX;
    logic [2:0]  funct3_IDEX;
    logic [31:0] rs1_data_IDEX;
    logic [31:0] rs2_data_IDEX;
    logic [4:0]  rd_IDEX;
    logic        flush_EX;
    logic        stall_EX;
    logic        done_EXMEM;
    logic [31:0] result_EXMEM;
    logic [4:0]  rd_EXMEM;
    logic        reg_wr_en_EXMEM;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(32), .CYCLES(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_IDEX      (start_IDEX),
        .funct3_IDEX     (funct3_IDEX),
        .rs1_data_IDEX   (rs1_data_IDEX),
        .rs2_data_IDEX   (rs2_data_IDEX),
        .rd_IDEX         (rd_IDEX),
        .flush_EX        (flush_EX),
        .stall_EX        (stall_EX),
        .done_EXMEM      (done_EXMEM),
        .result_EXMEM    (result_EXMEM),
        .rd_EXMEM        (rd_EXMEM),
        .reg_wr_en_EXMEM (reg_wr_en_EXMEM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a negedge: presents the op in this cycle (the issue cycle),
    // then expects done in issue cycle + exp_lat and stall high for exp_lat cycles.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input bit hold);
        int cyc;
        int nstall;
        bit got;
        start_IDEX    = 1'b1;
        funct3_IDEX   = f3;
        rs1_data_IDEX = a;
        rs2_data_IDEX = b;
        rd_IDEX       = rd;
        #1;
        check({name, " stall_issue"}, 32'(stall_EX), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) start_IDEX = 1'b0;
        rs1_data_IDEX = $urandom;
        rs2_data_IDEX = $urandom;
        rd_IDEX       = ~rd;
        cyc    = 0;
        nstall = 1;
        got    = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done_EXMEM) got = 1'b1;
            else if (stall_EX) nstall++;
        end
        check({name, " latency"}, 32'(cyc), 32'(exp_lat));
        check({name, " stall_cycles"}, 32'(nstall), 32'(exp_lat));
        check({name, " stall_in_done"}, 32'(stall_EX), 32'd0);
        check({name, " result"}, result_EXMEM, exp);
        check({name, " rd"}, 32'(rd_EXMEM), 32'(rd));
        check({name, " wr_en"}, 32'(reg_wr_en_EXMEM), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ndone;
        reset         = 1'b1;
        start_IDEX    = 1'b0;
        funct3_IDEX   = 3'd0;
        rs1_data_IDEX = 32'd0;
        rs2_data_IDEX = 32'd0;
        rd_IDEX       = 5'd0;
        flush_EX      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst done", 32'(done_EXMEM), 32'd0);
        check("rst wr_en", 32'(reg_wr_en_EXMEM), 32'd0);
        check("rst result", result_EXMEM, 32'd0);
        check("rst rd", 32'(rd_EXMEM), 32'd0);
        check("rst stall", 32'(stall_EX), 32'd0);
        reset = 1'b0;

        @(negedge clk); run_op("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 1'b0);
        @(negedge clk); run_op("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33, 1'b0);
        @(negedge clk); run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFF, 33, 1'b0);
        @(negedge clk); run_op("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33, 1'b0);
        @(negedge clk); run_op("DIV",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33, 1'b0);
        @(negedge clk); run_op("REM",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, 1'b0);
        @(negedge clk); run_op("DIVU",   3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        33, 1'b0);
        @(negedge clk); run_op("REMU",   3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         33, 1'b0);
        @(negedge clk); run_op("DIVU0",  3'b101, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1,  1'b0);
        @(negedge clk); run_op("REMU0",  3'b111, 32'd5,         32'd0,         5'd12, 32'd5,         1,  1'b0);
        @(negedge clk); run_op("DIVOVF", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1,  1'b0);
        @(negedge clk); run_op("REMOVF", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0,         1,  1'b0);

        // start held through DONE, then a new op presented in the following cycle
        @(negedge clk); run_op("HOLD", 3'b000, 32'd6, 32'd7, 5'd15, 32'd42, 33, 1'b1);
        funct3_IDEX   = 3'b101;
        rs1_data_IDEX = 32'd100;
        rs2_data_IDEX = 32'd7;
        rd_IDEX       = 5'd16;
        @(negedge clk);
        check("hold single_pulse", 32'(done_EXMEM), 32'd0);
        check("hold idle_stall", 32'(stall_EX), 32'd1);
        run_op("B2B DIVU", 3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 33, 1'b0);

        // flush during CALC
        @(negedge clk);
        start_IDEX = 1'b1; funct3_IDEX = 3'b000; rs1_data_IDEX = 32'd3; rs2_data_IDEX = 32'd5; rd_IDEX = 5'd17;
        @(posedge clk); #1;
        start_IDEX = 1'b0;
        repeat (9) @(negedge clk);
        flush_EX = 1'b1;
        @(negedge clk);
        flush_EX = 1'b0;
        check("flush stall", 32'(stall_EX), 32'd0);
        check("flush done", 32'(done_EXMEM), 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_EXMEM) ndone++;
        end
        check("flush no_pulse", 32'(ndone), 32'd0);

        // flush in IDLE blocks acceptance
        @(negedge clk);
        start_IDEX = 1'b1; flush_EX = 1'b1; funct3_IDEX = 3'b101; rs1_data_IDEX = 32'd9; rs2_data_IDEX = 32'd3;
        #1;
        check("idle_flush stall", 32'(stall_EX), 32'd0);
        @(negedge clk);
        start_IDEX = 1'b0; flush_EX = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_EXMEM) ndone++;
        end
        check("idle_flush no_pulse", 32'(ndone), 32'd0);

        // reset mid-CALC, then recover
        @(negedge clk);
        start_IDEX = 1'b1; funct3_IDEX = 3'b000; rs1_data_IDEX = 32'd7; rs2_data_IDEX = 32'd3; rd_IDEX = 5'd18;
        @(posedge clk); #1;
        start_IDEX = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst done", 32'(done_EXMEM), 32'd0);
        check("midrst wr_en", 32'(reg_wr_en_EXMEM), 32'd0);
        check("midrst result", result_EXMEM, 32'd0);
        check("midrst rd", 32'(rd_EXMEM), 32'd0);
        check("midrst stall", 32'(stall_EX), 32'd0);
        reset = 1'b0;
        @(negedge clk); run_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 5'd19, 32'd3, 33, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
